pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Fetch-side PC generator and IF/ID control for the 3-stage pipeline.
- Consumes the branch-decision stage's `take_branch` plus the EX-computed target.
- Drives the instruction-memory request handshake and the IF/ID valid/PC register.
- Squashes the wrong-path instruction on redirect and traps misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch address taken on a misaligned branch/jump target.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- stall_i, input, 1, hold IF/ID and PC (load-use or dmem wait).
- take_branch_i, input, 1, redirect request from the branch-decision stage (EX).
- br_target_i, input, 32, redirect target; valid when take_branch_i=1.
- imem_req_o, output, 1, instruction fetch request.
- imem_addr_o, output, 32, fetch address; equals pc_o.
- imem_gnt_i, input, 1, imem accepted the request this cycle.
- pc_o, output, 32, current fetch PC.
- if_id_valid_o, output, 1, IF/ID holds a live instruction.
- if_id_pc_o, output, 32, PC of the instruction in IF/ID.
- flush_o, output, 1, combinational; kill IF/ID contents this cycle.
- misalign_o, output, 1, registered 1-cycle pulse on a misaligned target.
- misalign_addr_o, output, 32, offending target, captured with misalign_o.

Behaviour:
- Reset (async assert, rst_n=0): state=BOOT, pc_o=RESET_PC, imem_req_o=0, if_id_valid_o=0, if_id_pc_o=0, misalign_o=0, misalign_addr_o=0.
- States: BOOT, RUN, TRAP.
- BOOT:
  - Lasts one cycle after rst_n deasserts.
  - imem_req_o=0; next state RUN.
  - take_branch_i is ignored.
- RUN:
  - imem_req_o=1, imem_addr_o=pc_o.
  - Request and address stay stable until imem_gnt_i, except on redirect.
- RUN next-state priority (highest first):
  1. take_branch_i=1 and br_target_i[1:0]==0:
     - pc<=br_target_i; if_id_valid<=0; flush_o=1.
     - Overrides stall_i and imem_gnt_i; a grant in the same cycle is discarded.
  2. take_branch_i=1 and br_target_i[1:0]!=0:
     - pc<=TRAP_VEC; if_id_valid<=0; flush_o=1.
     - misalign_o<=1; misalign_addr_o<=br_target_i; state<=TRAP.
  3. stall_i=1:
     - pc, if_id_valid, if_id_pc all held.
     - imem_req_o stays 1; a grant during stall is not consumed (refetched after stall).
  4. imem_gnt_i=1: pc<=pc+4 (wraps modulo 2^32); if_id_valid<=1; if_id_pc<=pc.
  5. imem_gnt_i=0: pc held; if_id_valid<=0 (bubble).
- TRAP:
  - One cycle; imem_req_o=0; misalign_o returns to 0; next state RUN.
  - take_branch_i is ignored in TRAP.
- flush_o:
  - Equals take_branch_i while in RUN, else 0.
  - Never asserted in BOOT or TRAP.
- Latency:
  - Redirect to first request at the target: 1 cycle.
  - Redirect to first valid IF/ID at the target: 2 cycles, assuming an immediate grant.
- Reset mid-operation: all state returns to reset values immediately; any outstanding grant is ignored.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- When defined, adds:
  - Outputs perf_redirect_o[PERF_W-1:0]: counts cycles taking priority 1 or 2.
  - perf_bubble_o[PERF_W-1:0]: counts priority-5 cycles.
  - Both counters reset to 0, saturate at all-ones, and do not count in BOOT or TRAP.
- When undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset release, imem_gnt_i=1 constant, no stall:
  - Cycle 1 BOOT, req=0.
  - Then pc_o = 0x0, 0x4, 0x8.
  - if_id_pc_o lags by one cycle with if_id_valid_o=1.
- At pc_o=0x10, take_branch_i=1, br_target_i=0x40:
  - flush_o=1 that cycle.
  - Next cycle pc_o=0x40, if_id_valid_o=0.
  - Cycle after: if_id_pc_o=0x40, valid=1.
- br_target_i=0x42 with take_branch_i=1:
  - Next cycle pc_o=0x100, misalign_o=1, misalign_addr_o=0x42, imem_req_o=0.
  - Following cycle misalign_o=0, req=1.
- stall_i=1 for 3 cycles with gnt=1:
  - pc_o, if_id_pc_o, if_id_valid_o unchanged.
  - After release, pc advances by 4 per cycle.
- stall_i=1 and take_branch_i=1 together, target 0x80:
  - Redirect wins: pc_o=0x80, if_id_valid_o=0.
- imem_gnt_i=0 for 2 cycles at pc 0x20:
  - imem_addr_o held at 0x20, two bubbles.
  - On grant, if_id_pc_o=0x20.
- With PC_FETCH_PERF_EN:
  - Same gnt-stall run yields perf_bubble_o=2.
  - Two redirects yield perf_redirect_o=2.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC generator and IF/ID control with redirect squash and misaligned-target trap.
// Optional performance counters are enabled by defining PC_FETCH_PERF_EN.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          PERF_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        take_branch_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    output logic [31:0] pc_o,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic        flush_o,
    output logic        misalign_o,
    output logic [31:0] misalign_addr_o
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_redirect_o,
    output logic [PERF_W-1:0] perf_bubble_o
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_e;

    state_e      state_q;
    logic        req_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        if_id_valid_q;
    logic [31:0] if_id_pc_q;
    logic        misalign_q;
    logic [31:0] misalign_addr_q;
    logic        redirect;

    // Branch decisions only matter once the fetch loop is running.
    assign redirect        = (state_q == RUN) && take_branch_i;
    assign pc_d            = pc_q + 32'd4;

    assign flush_o         = redirect;
    assign imem_req_o      = req_q;
    assign imem_addr_o     = pc_q;
    assign pc_o            = pc_q;
    assign if_id_valid_o   = if_id_valid_q;
    assign if_id_pc_o      = if_id_pc_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            req_q           <= 1'b0;
            pc_q            <= RESET_PC;
            if_id_valid_q   <= 1'b0;
            if_id_pc_q      <= 32'h0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= 32'h0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    req_q   <= 1'b1;
                end
                RUN: begin
                    if (take_branch_i) begin
                        if_id_valid_q <= 1'b0;
                        if (br_target_i[1:0] == 2'b00) begin
                            pc_q <= br_target_i;
                        end else begin
                            pc_q            <= TRAP_VEC;
                            misalign_q      <= 1'b1;
                            misalign_addr_q <= br_target_i;
                            state_q         <= TRAP;
                            req_q           <= 1'b0;
                        end
                    end else if (!stall_i) begin
                        // A grant seen during stall is dropped; the same PC is requested again.
                        if (imem_gnt_i) begin
                            pc_q          <= pc_d;
                            if_id_valid_q <= 1'b1;
                            if_id_pc_q    <= pc_q;
                        end else begin
                            if_id_valid_q <= 1'b0;
                        end
                    end
                end
                TRAP: begin
                    state_q <= RUN;
                    req_q   <= 1'b1;
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_PERF_EN
    logic [PERF_W-1:0] perf_redirect_q;
    logic [PERF_W-1:0] perf_bubble_q;
    logic              bubble;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign bubble = (state_q == RUN) && !take_branch_i && !stall_i && !imem_gnt_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirect_q <= '0;
            perf_bubble_q   <= '0;
        end else begin
            if (redirect) perf_redirect_q <= sat_inc(perf_redirect_q);
            if (bubble)   perf_bubble_q   <= sat_inc(perf_bubble_q);
        end
    end

    assign perf_redirect_o = perf_redirect_q;
    assign perf_bubble_o   = perf_bubble_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected post-edge state is queued with each stimulus step
// and popped for comparison one cycle later.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        take_branch_i;
    logic [31:0] br_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic [31:0] pc_o;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic        flush_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_redirect_o;
    logic [31:0] perf_bubble_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        vld;
        logic [31:0] idpc;
        logic        mis;
        logic [31:0] misaddr;
    } exp_t;

    exp_t sb[$];

    pc_fetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .take_branch_i   (take_branch_i),
        .br_target_i     (br_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .pc_o            (pc_o),
        .if_id_valid_o   (if_id_valid_o),
        .if_id_pc_o      (if_id_pc_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .misalign_addr_o (misalign_addr_o)
`ifdef PC_FETCH_PERF_EN
        ,
        .perf_redirect_o (perf_redirect_o),
        .perf_bubble_o   (perf_bubble_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check flush before the edge, state after it.
    task automatic step(input string tag, input logic st, input logic tb, input logic [31:0] tgt,
                        input logic gnt, input logic eflush, input logic [31:0] epc, input logic ereq,
                        input logic evld, input logic [31:0] eidpc, input logic emis,
                        input logic [31:0] emisaddr);
        exp_t e;
        stall_i       = st;
        take_branch_i = tb;
        br_target_i   = tgt;
        imem_gnt_i    = gnt;
        e.pc = epc; e.req = ereq; e.vld = evld; e.idpc = eidpc; e.mis = emis; e.misaddr = emisaddr;
        sb.push_back(e);
        #1;
        chk({tag, ".flush"}, {31'b0, flush_o}, {31'b0, eflush});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".pc"},   pc_o, e.pc);
            chk({tag, ".addr"}, imem_addr_o, e.pc);
            chk({tag, ".req"},  {31'b0, imem_req_o}, {31'b0, e.req});
            chk({tag, ".vld"},  {31'b0, if_id_valid_o}, {31'b0, e.vld});
            if (e.vld) chk({tag, ".idpc"}, if_id_pc_o, e.idpc);
            chk({tag, ".mis"},  {31'b0, misalign_o}, {31'b0, e.mis});
            if (e.mis) chk({tag, ".misaddr"}, misalign_addr_o, e.misaddr);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},      pc_o, 32'h0);
        chk({tag, ".req"},     {31'b0, imem_req_o}, 32'h0);
        chk({tag, ".vld"},     {31'b0, if_id_valid_o}, 32'h0);
        chk({tag, ".idpc"},    if_id_pc_o, 32'h0);
        chk({tag, ".mis"},     {31'b0, misalign_o}, 32'h0);
        chk({tag, ".misaddr"}, misalign_addr_o, 32'h0);
        chk({tag, ".flush"},   {31'b0, flush_o}, 32'h0);
`ifdef PC_FETCH_PERF_EN
        chk({tag, ".perf_redir"},  perf_redirect_o, 32'h0);
        chk({tag, ".perf_bubble"}, perf_bubble_o, 32'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; take_branch_i = 1'b0; br_target_i = 32'h0; imem_gnt_i = 1'b1;
        #12;
        chk_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        //   tag        st tb tgt            gnt fl pc             req vld idpc           mis misaddr
        step("boot",    0, 1, 32'h40,        1,  0, 32'h0,         1,  0,  32'h0,         0,  32'h0);
        step("seq0",    0, 0, 32'h0,         1,  0, 32'h4,         1,  1,  32'h0,         0,  32'h0);
        step("seq1",    0, 0, 32'h0,         1,  0, 32'h8,         1,  1,  32'h4,         0,  32'h0);
        step("seq2",    0, 0, 32'h0,         1,  0, 32'hC,         1,  1,  32'h8,         0,  32'h0);
        step("seq3",    0, 0, 32'h0,         1,  0, 32'h10,        1,  1,  32'hC,         0,  32'h0);
        step("br40",    0, 1, 32'h40,        1,  1, 32'h40,        1,  0,  32'h0,         0,  32'h0);
        step("br40_f",  0, 0, 32'h0,         1,  0, 32'h44,        1,  1,  32'h40,        0,  32'h0);
        step("mis42",   0, 1, 32'h42,        1,  1, 32'h100,       0,  0,  32'h0,         1,  32'h42);
        step("trap",    0, 1, 32'h80,        1,  0, 32'h100,       1,  0,  32'h0,         0,  32'h0);
        step("trap_f",  0, 0, 32'h0,         1,  0, 32'h104,       1,  1,  32'h100,       0,  32'h0);
        step("stall0",  1, 0, 32'h0,         1,  0, 32'h104,       1,  1,  32'h100,       0,  32'h0);
        step("stall1",  1, 0, 32'h0,         1,  0, 32'h104,       1,  1,  32'h100,       0,  32'h0);
        step("stall2",  1, 0, 32'h0,         1,  0, 32'h104,       1,  1,  32'h100,       0,  32'h0);
        step("unst0",   0, 0, 32'h0,         1,  0, 32'h108,       1,  1,  32'h104,       0,  32'h0);
        step("unst1",   0, 0, 32'h0,         1,  0, 32'h10C,       1,  1,  32'h108,       0,  32'h0);
        step("stbr80",  1, 1, 32'h80,        1,  1, 32'h80,        1,  0,  32'h0,         0,  32'h0);
        step("br20",    0, 1, 32'h20,        1,  1, 32'h20,        1,  0,  32'h0,         0,  32'h0);
        step("nogt0",   0, 0, 32'h0,         0,  0, 32'h20,        1,  0,  32'h0,         0,  32'h0);
        step("nogt1",   0, 0, 32'h0,         0,  0, 32'h20,        1,  0,  32'h0,         0,  32'h0);
        step("gnt20",   0, 0, 32'h0,         1,  0, 32'h24,        1,  1,  32'h20,        0,  32'h0);
        step("brtop",   0, 1, 32'hFFFF_FFFC, 1,  1, 32'hFFFF_FFFC, 1,  0,  32'h0,         0,  32'h0);
        step("wrap",    0, 0, 32'h0,         1,  0, 32'h0,         1,  1,  32'hFFFF_FFFC, 0,  32'h0);

`ifdef PC_FETCH_PERF_EN
        chk("perf_redir",  perf_redirect_o, 32'd5);
        chk("perf_bubble", perf_bubble_o, 32'd2);
`endif

        // Asynchronous reset in the middle of a cycle with a grant pending.
        stall_i = 1'b0; take_branch_i = 1'b0; imem_gnt_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(posedge clk); #1;
        chk_reset("midrst_hold");
        rst_n = 1'b1;
        step("boot2",   0, 0, 32'h0,         1,  0, 32'h0,         1,  0,  32'h0,         0,  32'h0);
        step("seq2_0",  0, 0, 32'h0,         1,  0, 32'h4,         1,  1,  32'h0,         0,  32'h0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
